vram_arbiter: RTL

- Sits between the host CPU bus and the text-mode video RAM, directly upstream of the RAM port that the vga scan-out reads.
- Gives the video fetch path absolute priority on the single-ported 16K x 8 VRAM.
- Buffers CPU writes in a small FIFO and drains them into free RAM cycles.
- Services one outstanding CPU read at a time, ordered after all earlier buffered writes.

---
 rtl/vram_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has absolute priority; CPU writes drain from a
// small FIFO and one CPU read is serviced after earlier writes. Option: VRAM_BLANK_ONLY_EN.
module vram_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic              cpu_ready,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [7:0]        vga_data,
  output logic              vga_valid,
  input  logic              hblank,
  input  logic              vblank,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_wen,
  input  logic [7:0]        ram_dout
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W+7:0]     fifo_mem [DEPTH];
  logic [FIFO_AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic [ADDR_W-1:0]     ram_addr_q;
  logic [7:0]            ram_din_q;
  logic                  vga_valid_q;
  logic [7:0]            vga_data_q;
  logic [7:0]            cpu_rdata_q;

  logic                  fifo_empty, fifo_full, full_d;
  logic [ADDR_W+7:0]     fifo_head;
  logic                  push, pop, rd_accept, rd_issue, cpu_slot_ok;

`ifdef VRAM_BLANK_ONLY_EN
  assign cpu_slot_ok = hblank || vblank;
`else
  logic unused_blank;
  assign unused_blank = hblank | vblank;
  assign cpu_slot_ok  = 1'b1;
`endif

  // Wrap-bit pointers: equal means empty, MSB-only difference means full.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];

  assign push      = cpu_we && cpu_ready_q && !reset;
  assign rd_accept = cpu_re && !cpu_we && cpu_ready_q && !reset;

  // RAM slot grant: video, then FIFO drain, then the pending read.
  always_comb begin
    ram_addr = ram_addr_q;
    ram_din  = ram_din_q;
    ram_wen  = 1'b0;
    pop      = 1'b0;
    rd_issue = 1'b0;
    if (reset) begin
      ram_addr = '0;
      ram_din  = '0;
    end else if (vga_req) begin
      ram_addr = vga_addr;
    end else if (!fifo_empty && cpu_slot_ok) begin
      pop               = 1'b1;
      ram_wen           = 1'b1;
      {ram_addr, ram_din} = fifo_head;
    end else if (rd_pending_q && fifo_empty && state_q == IDLE && cpu_slot_ok) begin
      rd_issue = 1'b1;
      ram_addr = rd_addr_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_pending_d = rd_pending_q;
    rd_addr_d    = rd_addr_q;
    case (state_q)
      IDLE:    if (rd_issue) state_d = RD_WAIT;
      RD_WAIT: begin
        state_d      = IDLE;
        rd_pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (rd_accept) begin
      rd_pending_d = 1'b1;
      rd_addr_d    = cpu_addr;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    full_d      = (wr_ptr_d[FIFO_AW] != rd_ptr_d[FIFO_AW]) &&
                  (wr_ptr_d[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]);
    cpu_ready_d = !full_d && !rd_pending_d;
  end

  // Read data arrives during RD_WAIT (synchronous RAM, one cycle after issue).
  assign cpu_ready  = cpu_ready_q;
  assign cpu_rvalid = (state_q == RD_WAIT) && !reset;
  assign cpu_rdata  = cpu_rvalid ? ram_dout : cpu_rdata_q;
  assign vga_valid  = vga_valid_q;
  assign vga_data   = vga_valid_q ? ram_dout : vga_data_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= {cpu_addr, cpu_wdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      cpu_ready_q  <= 1'b1;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      vga_valid_q  <= 1'b0;
      vga_data_q   <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_pending_q <= rd_pending_d;
      rd_addr_q    <= rd_addr_d;
      cpu_ready_q  <= cpu_ready_d;
      ram_addr_q   <= ram_addr;
      ram_din_q    <= ram_din;
      vga_valid_q  <= vga_req;
      vga_data_q   <= vga_data;
      cpu_rdata_q  <= cpu_rdata;
    end
  end

endmodule
